// File: rtl/aes_decrypt_iter_if.sv
// Request/response bundle for the iterative AES-128 decryptor.
// The master side supplies the block and key; the slave side returns the state and progress flags.
interface aes_decrypt_iter_if;
    logic         start;
    logic [127:0] cipher_text;
    logic [127:0] cipher_key;
    logic [127:0] plain_text;
    logic         done;
    logic [9:0]   completed_round;
    logic         busy;

    modport master (output start, cipher_text, cipher_key,
                    input  plain_text, done, completed_round, busy);
    modport slave  (input  start, cipher_text, cipher_key,
                    output plain_text, done, completed_round, busy);
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock. The key schedule is run forward to rk10
// and then walked backward alongside the rounds, so no round-key store is needed.
module aes_sbox #(
    parameter bit INV = 1'b0
) (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] aff;

    always_comb begin
        aff  = 8'h00;
        dout = 8'h00;
        if (!INV) begin
            aff  = gf_inv(din);
            dout = aff ^ {aff[6:0], aff[7]} ^ {aff[5:0], aff[7:6]}
                 ^ {aff[4:0], aff[7:5]} ^ {aff[3:0], aff[7:4]} ^ 8'h63;
        end else begin
            aff  = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
            dout = gf_inv(aff);
        end
    end
endmodule

module aes_decrypt_iter (
    input  logic               clk,
    input  logic               rst,
    aes_decrypt_iter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] pt_q, pt_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic [9:0]   cr_q, cr_d;
    logic [3:0]   rc_q, rc_d;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i sits at [127-8i -: 8]; row = i%4, column = i/4
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] o;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
        end
        for (int r = 0; r < 4; r++)
            o[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                           ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                           ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                           ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sb_in, rot_in, sb_out, temp;
    logic [127:0] fwd_key, bwd_key, isr, isb;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // Forward step substitutes w3; backward step substitutes the recovered w3' = w3^w2
    assign sb_in  = (state_q == KEXP) ? w3 : (w3 ^ w2);
    assign rot_in = {sb_in[23:0], sb_in[31:24]};
    assign temp   = sb_out ^ {rcon(rc_q), 24'h0};

    for (genvar i = 0; i < 4; i++) begin : g_fwd
        aes_sbox #(.INV(1'b0)) u_sbox (.din(rot_in[31-8*i -: 8]), .dout(sb_out[31-8*i -: 8]));
    end

    assign fwd_key[127:96] = w0 ^ temp;
    assign fwd_key[95:64]  = w1 ^ fwd_key[127:96];
    assign fwd_key[63:32]  = w2 ^ fwd_key[95:64];
    assign fwd_key[31:0]   = w3 ^ fwd_key[63:32];
    assign bwd_key         = {w0 ^ temp, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    assign isr = inv_shift_rows(pt_q);
    for (genvar i = 0; i < 16; i++) begin : g_inv
        aes_sbox #(.INV(1'b1)) u_isbox (.din(isr[127-8*i -: 8]), .dout(isb[127-8*i -: 8]));
    end

    // rc_q is the rcon index: 1..10 while expanding, then 10 down to 1 while walking back
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        ct_d    = ct_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        cr_d    = cr_q;
        busy_d  = busy_q;
        rc_d    = rc_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    key_d   = bus.cipher_key;
                    ct_d    = bus.cipher_text;
                    rc_d    = 4'd1;
                    busy_d  = 1'b1;
                    state_d = KEXP;
                end
            end
            KEXP: begin
                key_d = fwd_key;
                if (rc_q == 4'd10) state_d = INIT;
                else               rc_d    = rc_q + 4'd1;
            end
            INIT: begin
                pt_d    = ct_q ^ key_q;
                cr_d    = 10'd1;
                key_d   = bwd_key;
                rc_d    = 4'd9;
                state_d = ROUND;
            end
            ROUND: begin
                pt_d  = inv_mix(isb ^ key_q);
                cr_d  = 10'd1 << (4'd10 - rc_q);
                key_d = bwd_key;
                rc_d  = rc_q - 4'd1;
                if (rc_q == 4'd1) state_d = FINAL;
            end
            FINAL: begin
                pt_d    = isb ^ key_q;
                done_d  = 1'b1;
                cr_d    = 10'd0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            ct_q    <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
            cr_q    <= '0;
            busy_q  <= 1'b0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
            cr_q    <= cr_d;
            busy_q  <= busy_d;
            rc_q    <= rc_d;
        end
    end

    assign bus.plain_text      = pt_q;
    assign bus.done            = done_q;
    assign bus.completed_round = cr_q;
    assign bus.busy            = busy_q;
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: a textbook AES-128 inverse-cipher model with a cycle timeline
// is compared against every output on every falling edge, plus literal FIPS-197 vectors.
module tb_aes_decrypt_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_decrypt_iter_if bus ();
    aes_decrypt_iter dut (.clk(clk), .rst(rst), .bus(bus));

    localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_P  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_R1 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_C   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_P   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] Z_C   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam int NR = 30;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] trace_m [11];
    logic [127:0] exp_tr  [11];
    logic [127:0] exp_pt;
    bit           active, exp_done;
    int           cyc, acc;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Walk the multiplicative group with generator 3 and its inverse at the same time
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
            sbox[p] = x;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = i[7:0];
    endtask

    // Textbook InvCipher with a full 44-word schedule; trace_m[k] is the state after step k
    task automatic model_decrypt(input logic [127:0] key, input logic [127:0] ct);
        logic [31:0]  w [44];
        logic [127:0] rk [11];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [127:0] v;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        v = ct ^ rk[10];
        trace_m[0] = v;
        for (int rd = 9; rd >= 0; rd--) begin
            for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    u[4*c+r] = isbox[s[4*((c-r+4)%4)+r]];
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = u[i];
            v ^= rk[rd];
            if (rd > 0) begin
                for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        u[4*c+r] = gm(s[4*c+r], 8'h0e) ^ gm(s[4*c+(r+1)%4], 8'h0b)
                                 ^ gm(s[4*c+(r+2)%4], 8'h0d) ^ gm(s[4*c+(r+3)%4], 8'h09);
                for (int i = 0; i < 16; i++) v[127-8*i -: 8] = u[i];
            end
            trace_m[10-rd] = v;
        end
    endtask

    // Timeline model: accept at edge T, state updates at T+11..T+21, done after T+21
    initial begin
        active = 1'b0; exp_done = 1'b0; exp_pt = '0; cyc = 0; acc = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                active = 1'b0; exp_done = 1'b0; exp_pt = '0;
            end else begin
                cyc++;
                exp_done = 1'b0;
                if (active) begin
                    if (cyc - acc >= 11 && cyc - acc <= 21) exp_pt = exp_tr[cyc-acc-11];
                    if (cyc - acc == 21) begin
                        active = 1'b0; exp_done = 1'b1;
                    end
                end else if (bus.start) begin
                    active = 1'b1;
                    acc = cyc;
                    model_decrypt(bus.cipher_key, bus.cipher_text);
                    for (int i = 0; i < 11; i++) exp_tr[i] = trace_m[i];
                end
            end
        end
    end

    initial begin
        int d;
        logic [9:0] ecr;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst plain_text", bus.plain_text, 128'h0);
                chk("rst done", bus.done, 0);
                chk("rst completed_round", bus.completed_round, 0);
                chk("rst busy", bus.busy, 0);
            end else begin
                d = cyc - acc;
                ecr = (active && d >= 11 && d <= 20) ? (10'd1 << (d - 11)) : 10'd0;
                chk("plain_text", bus.plain_text, exp_pt);
                chk("done", bus.done, exp_done);
                chk("completed_round", bus.completed_round, ecr);
                chk("busy", bus.busy, active);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.done) n++;
        end
    endtask

    task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                             input logic [127:0] pt, input string nm);
        int lat;
        bus.cipher_key  = key;
        bus.cipher_text = ct;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(lat);
        chk({nm, " latency"}, lat, 21);
        chk({nm, " plaintext"}, bus.plain_text, pt);
    endtask

    initial begin
        int n, gap, ndone, guard;
        bus.start = 1'b0;
        bus.cipher_key = '0;
        bus.cipher_text = '0;
        rst = 1'b1;

        build_tables();
        model_decrypt(C1_K, C1_C);
        chk("model C.1 pt", trace_m[10], C1_P);
        chk("model C.1 round1", trace_m[0], C1_R1);
        model_decrypt(B_K, B_C);
        chk("model AppB pt", trace_m[10], B_P);
        model_decrypt(128'h0, Z_C);
        chk("model zero pt", trace_m[10], 128'h0);

        repeat (3) step();
        rst = 1'b0;
        step();

        run_block(C1_K, C1_C, C1_P, "C.1");
        run_block(B_K, B_C, B_P, "AppB");
        run_block(128'h0, Z_C, 128'h0, "zero");

        // Back-to-back with start held high; inputs advance on each done
        bus.cipher_key  = {$urandom, $urandom, $urandom, $urandom};
        bus.cipher_text = {$urandom, $urandom, $urandom, $urandom};
        bus.start = 1'b1;
        ndone = 0; gap = 0; guard = 0;
        while (ndone < NR && guard < NR * 30) begin
            step();
            guard++;
            gap++;
            if (bus.done) begin
                if (ndone > 0) chk("b2b spacing", gap, 22);
                gap = 0;
                ndone++;
                bus.cipher_key  = {$urandom, $urandom, $urandom, $urandom};
                bus.cipher_text = {$urandom, $urandom, $urandom, $urandom};
                if (ndone == NR) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("b2b block count", ndone, NR);
        step();

        // Start pulse while busy is ignored
        bus.cipher_key = C1_K; bus.cipher_text = C1_C; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        bus.cipher_key = B_K; bus.cipher_text = B_C; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(n);
        chk("ignored start latency", n, 16);
        chk("ignored start plaintext", bus.plain_text, C1_P);
        step();

        // Reset at cycle 15 of a block aborts it
        bus.cipher_key = B_K; bus.cipher_text = B_C; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (14) step();
        rst = 1'b1;
        #1;
        chk("async rst plain_text", bus.plain_text, 128'h0);
        chk("async rst round", bus.completed_round, 0);
        chk("async rst busy", bus.busy, 0);
        repeat (2) step();
        rst = 1'b0;
        count_dones(30, n);
        chk("aborted block done count", n, 0);
        run_block(C1_K, C1_C, C1_P, "C.1 after rst");
        step();

        // Reset coinciding with start
        bus.cipher_key = B_K; bus.cipher_text = B_C; bus.start = 1'b1; rst = 1'b1;
        repeat (2) step();
        bus.start = 1'b0; rst = 1'b0;
        count_dones(30, n);
        chk("rst with start done count", n, 0);

        // Reset across the edge that would raise done
        bus.cipher_key = C1_K; bus.cipher_text = C1_C; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (20) step();
        rst = 1'b1;
        #1;
        chk("rst at done plain_text", bus.plain_text, 128'h0);
        repeat (2) step();
        rst = 1'b0;
        count_dones(30, n);
        chk("rst at done done count", n, 0);
        run_block(B_K, B_C, B_P, "AppB after rst");
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes_decrypt_iter.md
Name: aes_decrypt_iter

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 InvCipher), one round per clock. It is the receive-side counterpart of the AES_top encryptor.
- Exposes the same start/done/completed_round/round-data interface, so the existing SISO bench style and reference vector files drive it unchanged.
- Runs the key schedule forward to the last round key, then walks it backward while decrypting. No 11-entry key store.
- Uses the shared forward and inverse S-box lookup modules; no private tables.

Parameters:
- None. AES-128 only; Nr fixed at 10.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level request; sampled only in IDLE
- cipher_text  in  128  ciphertext; [127:120] = FIPS input byte 0, column-major
- cipher_key  in  128  AES-128 key, same byte order
- plain_text  out  128  state register; intermediate round data while busy, plaintext when done=1
- done  out  1  one-cycle pulse; plain_text valid
- completed_round  out  10  one-hot round-progress marker, else 0
- busy  out  1  high from the start-accept edge until the edge that raises done

Behaviour:
- Reset (async, rst=1): FSM=IDLE; plain_text=0, done=0, completed_round=0, busy=0; key and round counters cleared.
- Reset mid-operation aborts immediately. No done is produced for the aborted block. After release the FSM returns to IDLE.
- FSM states: IDLE, KEXP, INIT, ROUND, FINAL.
- IDLE, start=1 at edge T:
  - latch cipher_key into key_reg and cipher_text into ct_reg
  - rc=1, go to KEXP, busy=1
- KEXP, edges T+1..T+10: forward schedule step key_reg <= next(key_reg, rcon[rc]); rc++. After edge T+10, key_reg = rk10. Go to INIT.
- INIT, edge T+11:
  - plain_text <= ct_reg ^ rk10
  - completed_round <= 10'b0000000001
  - key_reg <= rk9 via backward step; go to ROUND, r=1
- ROUND r=1..9, edges T+12..T+20:
  - plain_text <= InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ rk(10-r))
  - completed_round <= 1<<r
  - key_reg steps back to rk(9-r)
  - after r=9 go to FINAL
- FINAL, edge T+21:
  - plain_text <= InvSubBytes(InvShiftRows(s)) ^ rk0
  - done <= 1, completed_round <= 0, busy <= 0
  - go to IDLE
- done is high exactly one cycle, the cycle after edge T+21. Latency from start-accept edge to done high: 21 cycles.
- Backward key step from rk_i (words w0..w3) to rk_{i-1}:
  - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0
  - w0'=w0^SubWord(RotWord(w3'))^rcon_i
  - rcon sequence 01,02,04,08,10,20,40,80,1b,36
- Forward step is standard FIPS-197. Both steps share the four forward S-box instances.
- GF(2^8) xtime reduces by 0x1b. InvMixColumns coefficients are 0e,0b,0d,09.
- Start handling:
  - start is ignored while busy; its level is not queued.
  - start held high gives back-to-back operation: the next block is accepted at edge T+22 (the done-high cycle is IDLE). Sustained period is 22 cycles.
  - Inputs are sampled only at the accept edge. Changing cipher_text or cipher_key while busy has no effect.
- plain_text holds its last value in IDLE until the next INIT edge.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, done exactly 21 cycles after accept. At the completed_round=0000000001 cycle, plain_text = 7ad5fda789ef4e272bca100b3d9ff59f.
- FIPS-197 App B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734. completed_round walks bits 0..9 on consecutive cycles, one-hot.
- All-zero key, ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> pt 00000000000000000000000000000000.
- start held high, 1000 vectors from ../../ref/cipher_text.txt, cipher_key.txt and plain_text.txt, inputs advanced on done -> every output matches, done spacing exactly 22 cycles, zero mismatches.
- Pulse start mid-operation (cycle 5 of busy) with different inputs -> ignored; first result correct. Then assert rst at cycle 15 of a block -> all outputs 0 asynchronously, no done. A fresh start after release gives correct C.1 result.
- rst asserted in the same cycle as start and as done -> reset wins: IDLE, outputs 0, no further done.
